roce_dma_wr_splitter: RTL and testbench
=======================================

// Module: roce_dma_wr_splitter
// PURPOSE
// - Sits directly downstream of the RoCE stack's memory-write command/data outputs, upstream of the host DMA engine.
// - Splits each write {vaddr,len} so that no DMA command crosses a BOUNDARY-byte page.
// - Re-frames the data stream so that TLAST closes every sub-command.
// - Counts splits and flags command/data length mismatches.
// PARAMETERS
// DATA_W    512   data beat width (bits); BEAT_B = DATA_W/8
// ADDR_W    64    virtual address width
// LEN_W     32    byte length width
// DEST_W    4     TDEST width (passed through unchanged)
// BOUNDARY  4096  page size in bytes; power of two, >= BEAT_B
// PORTS
// net_clk                  in   1             clock
// net_areset               in   1             asynchronous, active-high reset
// s_axis_wr_cmd_valid      in   1             command in: valid
// s_axis_wr_cmd_ready      out  1             command in: ready
// s_axis_wr_cmd_data       in   ADDR_W+LEN_W  {len, vaddr}; vaddr in LSBs
// s_axis_wr_cmd_dest       in   DEST_W        command destination
// s_axis_wr_data_valid     in   1             data in: valid
// s_axis_wr_data_ready     out  1             data in: ready
// s_axis_wr_data_data      in   DATA_W        data in: payload
// s_axis_wr_data_keep      in   DATA_W/8      data in: byte enables
// s_axis_wr_data_last      in   1             data in: last beat
// m_axis_wr_cmd_valid      out  1             sub-command out: valid
// m_axis_wr_cmd_ready      in   1             sub-command out: ready
// m_axis_wr_cmd_data       out  ADDR_W+LEN_W  sub-command out: {len, vaddr}
// m_axis_wr_cmd_dest       out  DEST_W        sub-command out: destination
// m_axis_wr_data_*         out/in             data out; fields mirror s_axis_wr_data_* plus _dest (DEST_W)
// split_count              out  32            sub-commands issued beyond the first, wrapping
// len_err                  out  1             one-cycle pulse on a length mismatch
// BEHAVIOUR
// - Reset: all valids 0, both input readies 0, split_count 0, len_err 0, FSM IDLE.
// - FSM:
//   - IDLE: cmd ready=1. On accept, latch addr/rem_len/dest and go to ISSUE.
//   - ISSUE: sub_len = min(rem_len, BOUNDARY - addr[log2(BOUNDARY)-1:0]).
//     - Drive m_axis_wr_cmd from registers; hold valid until ready.
//     - On the handshake: beats = ceil(sub_len/BEAT_B), go to DATA.
//   - DATA: s_axis_wr_data_ready = m_axis_wr_data_ready (combinational pass-through, zero latency; payload, keep and dest untouched).
//     - m_last = (beat_cnt==beats-1).
//     - On m_last handshake: addr += sub_len, rem_len -= sub_len.
//     - If rem_len==0 go to IDLE; otherwise split_count++ and return to ISSUE.
// - Throughput: one bubble cycle per sub-command (ISSUE); no data beat is accepted while in ISSUE.
// - Alignment: vaddr must be BEAT_B aligned so page boundaries fall on beat edges.
//   - A misaligned vaddr: issue one unsplit command, pulse len_err.
// - len==0: issue one command with len 0 and no data phase; return to IDLE.
// - Input last asserted before the final beat of the whole command: still forwarded, framing follows the count; pulse len_err.
// - Input last missing on the final beat: same response.
// - Widths: sub_len arithmetic in LEN_W bits; addr add in ADDR_W bits, wraps at 2^ADDR_W; split_count wraps at 2^32-1 -> 0.
// - Simultaneous events: a new command is not accepted until the FSM returns to IDLE; backpressure on either output stalls the FSM without loss.
// - Reset mid-operation: asynchronously clears everything; in-flight beats are dropped, and upstream re-sends after reset.
// STRUCTURE
// - roce_pkg: dma_cmd_t {len, vaddr} struct, BEAT_B and PAGE_MASK localparams, splitter state enum.
// - One sub-module, roce_wr_split_calc: combinational sub_len/beats computation, kept isolated for unit test.
// - Everything else (FSM, counters, output registers) lives in this module.
// TESTING
// - T1: cmd vaddr=0x1000, len=4096 -> one sub-cmd {0x1000,4096}; 64 beats, last on beat 63; split_count=0.
// - T2: cmd vaddr=0x1FC0, len=128 -> sub-cmds {0x1FC0,64}, {0x2000,64}; last on beats 0 and 1; split_count=1.
// - T3: vaddr=0x0F00, len=10000 -> {0xF00,256}, {0x1000,4096}, {0x2000,4096}, {0x3000,1552}; beats 4/64/64/25.
// - T4: random backpressure on m_axis_wr_cmd_ready and m_axis_wr_data_ready -> bit-exact data order, no duplicates, no drops.
// - T5: input last on beat 3 of an 8-beat cmd -> len_err pulses exactly once; output framing is still 8 beats.
// - T6: assert net_areset during DATA of T3 -> all valids 0 the same cycle; the next cmd (vaddr=0, len=64) completes normally.

Source files
------------

// File: rtl/roce_pkg.sv
// Shared types and constants for the RoCE DMA write splitter.
// Widths are fixed here; the command struct and the splitter state are built from them.
package roce_pkg;

  localparam int unsigned DATA_W    = 512;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned LEN_W     = 32;
  localparam int unsigned DEST_W    = 4;
  localparam int unsigned BOUNDARY  = 4096;
  localparam int unsigned BEAT_B    = DATA_W / 8;
  localparam int unsigned BEAT_BITS = $clog2(BEAT_B);
  localparam int unsigned PAGE_BITS = $clog2(BOUNDARY);
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(BOUNDARY - 1);

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] vaddr;
  } dma_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } split_state_e;

  // Shift-and-round-up form avoids the carry out of (len + BEAT_B - 1).
  function automatic logic [LEN_W-1:0] ceil_beats(input logic [LEN_W-1:0] len);
    return (len >> BEAT_BITS) + LEN_W'(|len[BEAT_BITS-1:0]);
  endfunction

endpackage

// File: rtl/roce_wr_split_calc.sv
// Sub-command sizing: bytes left before the next page boundary, clipped to what remains,
// and the number of data beats that sub-command occupies.
module roce_wr_split_calc
  import roce_pkg::*;
(
  input  logic [PAGE_BITS-1:0] i_page_off,
  input  logic [LEN_W-1:0]     i_rem_len,
  input  logic                 i_unsplit,
  output logic [LEN_W-1:0]     o_sub_len,
  output logic [LEN_W-1:0]     o_beats
);

  logic [LEN_W-1:0] w_room;

  assign w_room    = LEN_W'(BOUNDARY) - LEN_W'(i_page_off);
  // A misaligned command is passed through whole rather than split mid-beat.
  assign o_sub_len = (i_unsplit || (i_rem_len <= w_room)) ? i_rem_len : w_room;
  assign o_beats   = ceil_beats(o_sub_len);

endmodule

// File: rtl/roce_dma_wr_splitter.sv
// Splits RoCE memory-write commands at page boundaries and re-frames the data stream
// so TLAST closes every sub-command; counts splits and flags length mismatches.
module roce_dma_wr_splitter
  import roce_pkg::*;
(
  input  logic                     net_clk,
  input  logic                     net_areset,
  input  logic                     s_axis_wr_cmd_valid,
  output logic                     s_axis_wr_cmd_ready,
  input  logic [ADDR_W+LEN_W-1:0]  s_axis_wr_cmd_data,
  input  logic [DEST_W-1:0]        s_axis_wr_cmd_dest,
  input  logic                     s_axis_wr_data_valid,
  output logic                     s_axis_wr_data_ready,
  input  logic [DATA_W-1:0]        s_axis_wr_data_data,
  input  logic [BEAT_B-1:0]        s_axis_wr_data_keep,
  input  logic                     s_axis_wr_data_last,
  output logic                     m_axis_wr_cmd_valid,
  input  logic                     m_axis_wr_cmd_ready,
  output logic [ADDR_W+LEN_W-1:0]  m_axis_wr_cmd_data,
  output logic [DEST_W-1:0]        m_axis_wr_cmd_dest,
  output logic                     m_axis_wr_data_valid,
  input  logic                     m_axis_wr_data_ready,
  output logic [DATA_W-1:0]        m_axis_wr_data_data,
  output logic [BEAT_B-1:0]        m_axis_wr_data_keep,
  output logic                     m_axis_wr_data_last,
  output logic [DEST_W-1:0]        m_axis_wr_data_dest,
  output logic [31:0]              split_count,
  output logic                     len_err
);

  split_state_e      r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem_len;
  logic [LEN_W-1:0]  r_sub_len;
  logic [LEN_W-1:0]  r_beats;
  logic [LEN_W-1:0]  r_beat_cnt;
  logic [DEST_W-1:0] r_dest;
  logic              r_unsplit;
  logic              r_err_seen;
  logic              r_cmd_valid;
  logic              r_cmd_ready;
  logic              r_len_err;
  logic [31:0]       r_split_count;

  logic [PAGE_BITS-1:0] w_page_off;
  logic [LEN_W-1:0]     w_sub_len;
  logic [LEN_W-1:0]     w_beats;
  dma_cmd_t             w_cmd_in;
  dma_cmd_t             w_cmd_out;
  logic                 w_misalign;
  logic                 w_in_data;
  logic                 w_cmd_hs;
  logic                 w_beat_hs;
  logic                 w_m_last;
  logic                 w_final_sub;
  logic                 w_last_err;

  assign w_page_off = PAGE_BITS'(r_addr & PAGE_MASK);

  roce_wr_split_calc u_calc (
    .i_page_off (w_page_off),
    .i_rem_len  (r_rem_len),
    .i_unsplit  (r_unsplit),
    .o_sub_len  (w_sub_len),
    .o_beats    (w_beats)
  );

  assign w_cmd_in   = dma_cmd_t'(s_axis_wr_cmd_data);
  assign w_misalign = |w_cmd_in.vaddr[BEAT_BITS-1:0];
  assign w_cmd_out  = '{len: w_sub_len, vaddr: r_addr};
  assign w_cmd_hs   = r_cmd_valid & m_axis_wr_cmd_ready;

  // Data phase is a zero-latency pass-through gated only by the FSM.
  assign w_in_data   = (r_state == ST_DATA);
  assign w_beat_hs   = w_in_data & s_axis_wr_data_valid & m_axis_wr_data_ready;
  assign w_m_last    = (r_beat_cnt == (r_beats - LEN_W'(1)));
  assign w_final_sub = (r_rem_len == r_sub_len);
  // Input TLAST must coincide with the final beat of the whole command.
  assign w_last_err  = w_beat_hs & (s_axis_wr_data_last != (w_m_last & w_final_sub));

  assign s_axis_wr_cmd_ready  = r_cmd_ready;
  assign s_axis_wr_data_ready = w_in_data & m_axis_wr_data_ready;
  assign m_axis_wr_cmd_valid  = r_cmd_valid;
  assign m_axis_wr_cmd_data   = w_cmd_out;
  assign m_axis_wr_cmd_dest   = r_dest;
  assign m_axis_wr_data_valid = w_in_data & s_axis_wr_data_valid;
  assign m_axis_wr_data_data  = s_axis_wr_data_data;
  assign m_axis_wr_data_keep  = s_axis_wr_data_keep;
  assign m_axis_wr_data_last  = w_m_last;
  assign m_axis_wr_data_dest  = r_dest;
  assign split_count          = r_split_count;
  assign len_err              = r_len_err;

  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_rem_len     <= '0;
      r_sub_len     <= '0;
      r_beats       <= '0;
      r_beat_cnt    <= '0;
      r_dest        <= '0;
      r_unsplit     <= 1'b0;
      r_err_seen    <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_len_err     <= 1'b0;
      r_split_count <= '0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_cmd_ready && s_axis_wr_cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= w_cmd_in.vaddr;
            r_rem_len   <= w_cmd_in.len;
            r_dest      <= s_axis_wr_cmd_dest;
            r_unsplit   <= w_misalign;
            r_err_seen  <= w_misalign;
            r_len_err   <= w_misalign;
            r_cmd_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (w_cmd_hs) begin
            r_cmd_valid <= 1'b0;
            r_sub_len   <= w_sub_len;
            r_beats     <= w_beats;
            r_beat_cnt  <= '0;
            r_state     <= (w_sub_len == '0) ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_beat_hs) begin
            // Report at most one mismatch per command even if TLAST is both early and missing.
            if (w_last_err && !r_err_seen) begin
              r_len_err  <= 1'b1;
              r_err_seen <= 1'b1;
            end
            if (w_m_last) begin
              r_addr     <= r_addr + ADDR_W'(r_sub_len);
              r_rem_len  <= r_rem_len - r_sub_len;
              r_beat_cnt <= '0;
              if (w_final_sub) begin
                r_state <= ST_IDLE;
              end else begin
                r_split_count <= r_split_count + 32'd1;
                r_cmd_valid   <= 1'b1;
                r_state       <= ST_ISSUE;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_valid <= 1'b0;
          r_cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_roce_dma_wr_splitter.sv
// Scoreboard bench for roce_dma_wr_splitter: directed commands push hand-computed
// sub-commands and beat framing; negedge monitors pop and compare on each output handshake.
module tb_roce_dma_wr_splitter;

  logic         net_clk;
  logic         net_areset;
  logic         s_cmd_valid, s_cmd_ready;
  logic [95:0]  s_cmd_data;
  logic [3:0]   s_cmd_dest;
  logic         s_data_valid, s_data_ready;
  logic [511:0] s_data_data;
  logic [63:0]  s_data_keep;
  logic         s_data_last;
  logic         m_cmd_valid, m_cmd_ready;
  logic [95:0]  m_cmd_data;
  logic [3:0]   m_cmd_dest;
  logic         m_data_valid, m_data_ready;
  logic [511:0] m_data_data;
  logic [63:0]  m_data_keep;
  logic         m_data_last;
  logic [3:0]   m_data_dest;
  logic [31:0]  split_count;
  logic         len_err;

  roce_dma_wr_splitter dut (
    .net_clk              (net_clk),
    .net_areset           (net_areset),
    .s_axis_wr_cmd_valid  (s_cmd_valid),
    .s_axis_wr_cmd_ready  (s_cmd_ready),
    .s_axis_wr_cmd_data   (s_cmd_data),
    .s_axis_wr_cmd_dest   (s_cmd_dest),
    .s_axis_wr_data_valid (s_data_valid),
    .s_axis_wr_data_ready (s_data_ready),
    .s_axis_wr_data_data  (s_data_data),
    .s_axis_wr_data_keep  (s_data_keep),
    .s_axis_wr_data_last  (s_data_last),
    .m_axis_wr_cmd_valid  (m_cmd_valid),
    .m_axis_wr_cmd_ready  (m_cmd_ready),
    .m_axis_wr_cmd_data   (m_cmd_data),
    .m_axis_wr_cmd_dest   (m_cmd_dest),
    .m_axis_wr_data_valid (m_data_valid),
    .m_axis_wr_data_ready (m_data_ready),
    .m_axis_wr_data_data  (m_data_data),
    .m_axis_wr_data_keep  (m_data_keep),
    .m_axis_wr_data_last  (m_data_last),
    .m_axis_wr_data_dest  (m_data_dest),
    .split_count          (split_count),
    .len_err              (len_err)
  );

  initial net_clk = 1'b0;
  always #5 net_clk = ~net_clk;

  typedef struct {
    logic [95:0] cmd;
    logic [3:0]  dest;
  } exp_cmd_t;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [3:0]   dest;
  } exp_beat_t;

  exp_cmd_t    exp_cmd_q[$];
  exp_beat_t   exp_beat_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned g_seq    = 0;
  int unsigned e_seq    = 0;
  int unsigned lerr_cnt = 0;
  bit          bp_mode  = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [511:0] pat_data(input int unsigned s);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = (s * 32'h0100_0193) + 32'(i);
    return d;
  endfunction

  function automatic logic [63:0] pat_keep(input int unsigned s);
    logic [31:0] k;
    k = ~(s * 32'h9E37_79B1);
    return {k, ~k};
  endfunction

  // One expected sub-command plus its beats; TLAST only on the final beat of each sub-command.
  task automatic push_sub(input logic [63:0] a, input logic [31:0] l, input logic [3:0] d);
    exp_cmd_t  c;
    exp_beat_t b;
    int unsigned nb;
    c.cmd  = {l, a};
    c.dest = d;
    exp_cmd_q.push_back(c);
    nb = (l + 32'd63) / 32'd64;
    for (int unsigned i = 0; i < nb; i++) begin
      b.data = pat_data(e_seq);
      b.keep = pat_keep(e_seq);
      b.last = (i == nb - 1);
      b.dest = d;
      exp_beat_q.push_back(b);
      e_seq++;
    end
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [31:0] l, input logic [3:0] d);
    int t;
    t = 0;
    @(posedge net_clk); #1;
    s_cmd_valid = 1'b1;
    s_cmd_data  = {l, a};
    s_cmd_dest  = d;
    @(negedge net_clk);
    while (!s_cmd_ready && t < 2000) begin
      @(negedge net_clk);
      t++;
    end
    check("cmd_accept", s_cmd_ready, 1);
    @(posedge net_clk); #1;
    s_cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int n, input int last_idx);
    int t;
    for (int i = 0; i < n; i++) begin
      if (bp_mode) repeat ($urandom_range(0, 2)) @(posedge net_clk);
      #1;
      s_data_valid = 1'b1;
      s_data_data  = pat_data(g_seq);
      s_data_keep  = pat_keep(g_seq);
      s_data_last  = (i == last_idx);
      t = 0;
      @(negedge net_clk);
      while (!s_data_ready && t < 2000) begin
        @(negedge net_clk);
        t++;
      end
      if (!s_data_ready) begin
        check("beat_accept", s_data_ready, 1);
        s_data_valid = 1'b0;
        return;
      end
      g_seq++;
      @(posedge net_clk); #1;
      s_data_valid = 1'b0;
      s_data_last  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge net_clk);
    while (!(exp_cmd_q.size() == 0 && exp_beat_q.size() == 0 && s_cmd_ready) && t < 2000) begin
      @(negedge net_clk);
      t++;
    end
    check("drain_cmd_q", 32'(exp_cmd_q.size()), 0);
    check("drain_beat_q", 32'(exp_beat_q.size()), 0);
  endtask

  // Output-side ready pattern, random only while bp_mode is set.
  initial begin
    m_cmd_ready  = 1'b1;
    m_data_ready = 1'b1;
    forever begin
      @(posedge net_clk); #1;
      if (bp_mode) begin
        m_cmd_ready  = ($urandom_range(0, 1) == 1);
        m_data_ready = ($urandom_range(0, 3) != 0);
      end else begin
        m_cmd_ready  = 1'b1;
        m_data_ready = 1'b1;
      end
    end
  end

  always @(negedge net_clk) begin
    exp_cmd_t c;
    if (!net_areset && m_cmd_valid && m_cmd_ready) begin
      if (exp_cmd_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_cmd: got %0h, expected none", m_cmd_data);
      end else begin
        c = exp_cmd_q.pop_front();
        check("sub_cmd", m_cmd_data, c.cmd);
        check("sub_cmd_dest", m_cmd_dest, c.dest);
      end
    end
  end

  always @(negedge net_clk) begin
    exp_beat_t b;
    if (!net_areset && m_data_valid && m_data_ready) begin
      if (exp_beat_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got %0h, expected none", m_data_data[63:0]);
      end else begin
        b = exp_beat_q.pop_front();
        check("beat_data", m_data_data, b.data);
        check("beat_keep", m_data_keep, b.keep);
        check("beat_last", m_data_last, b.last);
        check("beat_dest", m_data_dest, b.dest);
      end
    end
  end

  always @(negedge net_clk) begin
    if (!net_areset && len_err) lerr_cnt++;
  end

  initial begin
    int unsigned lerr_base;
    net_areset   = 1'b1;
    s_cmd_valid  = 1'b0;
    s_cmd_data   = '0;
    s_cmd_dest   = '0;
    s_data_valid = 1'b0;
    s_data_data  = '0;
    s_data_keep  = '0;
    s_data_last  = 1'b0;

    repeat (3) @(posedge net_clk);
    #1;
    check("rst_cmd_ready", s_cmd_ready, 0);
    check("rst_data_ready", s_data_ready, 0);
    check("rst_m_cmd_valid", m_cmd_valid, 0);
    check("rst_m_data_valid", m_data_valid, 0);
    check("rst_split_count", split_count, 0);
    check("rst_len_err", len_err, 0);
    @(negedge net_clk);
    net_areset = 1'b0;

    // T1: page-aligned full page, no split
    lerr_base = lerr_cnt;
    push_sub(64'h1000, 32'd4096, 4'h3);
    send_cmd(64'h1000, 32'd4096, 4'h3);
    send_beats(64, 63);
    wait_idle();
    check("t1_split_count", split_count, 0);
    check("t1_len_err", 32'(lerr_cnt - lerr_base), 0);

    // T2: two beats straddling a boundary
    lerr_base = lerr_cnt;
    push_sub(64'h1FC0, 32'd64, 4'h5);
    push_sub(64'h2000, 32'd64, 4'h5);
    send_cmd(64'h1FC0, 32'd128, 4'h5);
    send_beats(2, 1);
    wait_idle();
    check("t2_split_count", split_count, 1);
    check("t2_len_err", 32'(lerr_cnt - lerr_base), 0);

    // T3: four sub-commands, 4/64/64/25 beats
    lerr_base = lerr_cnt;
    push_sub(64'h0F00, 32'd256,  4'hA);
    push_sub(64'h1000, 32'd4096, 4'hA);
    push_sub(64'h2000, 32'd4096, 4'hA);
    push_sub(64'h3000, 32'd1552, 4'hA);
    send_cmd(64'h0F00, 32'd10000, 4'hA);
    send_beats(157, 156);
    wait_idle();
    check("t3_split_count", split_count, 4);
    check("t3_len_err", 32'(lerr_cnt - lerr_base), 0);

    // T4: random backpressure on both outputs and gaps on input data
    bp_mode   = 1'b1;
    lerr_base = lerr_cnt;
    push_sub(64'h0E80, 32'd384,  4'h7);
    push_sub(64'h1000, 32'd4096, 4'h7);
    push_sub(64'h2000, 32'd128,  4'h7);
    send_cmd(64'h0E80, 32'd4608, 4'h7);
    send_beats(72, 71);
    wait_idle();
    bp_mode = 1'b0;
    check("t4_split_count", split_count, 6);
    check("t4_len_err", 32'(lerr_cnt - lerr_base), 0);

    // T5: early input last on beat 3 of 8; framing still follows the count
    lerr_base = lerr_cnt;
    push_sub(64'h4000, 32'd512, 4'h2);
    send_cmd(64'h4000, 32'd512, 4'h2);
    send_beats(8, 3);
    wait_idle();
    check("t5_split_count", split_count, 6);
    check("t5_len_err", 32'(lerr_cnt - lerr_base), 1);

    // Misaligned vaddr crossing a page: passed through whole, flagged
    lerr_base = lerr_cnt;
    push_sub(64'h0FF8, 32'd100, 4'h9);
    send_cmd(64'h0FF8, 32'd100, 4'h9);
    send_beats(2, 1);
    wait_idle();
    check("mis_split_count", split_count, 6);
    check("mis_len_err", 32'(lerr_cnt - lerr_base), 1);

    // Zero length: one command, no data phase
    lerr_base = lerr_cnt;
    push_sub(64'h5000, 32'd0, 4'h1);
    send_cmd(64'h5000, 32'd0, 4'h1);
    wait_idle();
    check("len0_split_count", split_count, 6);
    check("len0_len_err", 32'(lerr_cnt - lerr_base), 0);

    // T6: reset in the middle of T3's second sub-command
    push_sub(64'h0F00, 32'd256,  4'hC);
    push_sub(64'h1000, 32'd4096, 4'hC);
    push_sub(64'h2000, 32'd4096, 4'hC);
    push_sub(64'h3000, 32'd1552, 4'hC);
    send_cmd(64'h0F00, 32'd10000, 4'hC);
    send_beats(10, -1);
    s_data_valid = 1'b1;
    s_data_data  = pat_data(g_seq);
    s_data_keep  = pat_keep(g_seq);
    #1;
    check("t6_pre_rst_data_valid", m_data_valid, 1);
    #1;
    net_areset = 1'b1;
    #1;
    check("t6_rst_m_data_valid", m_data_valid, 0);
    check("t6_rst_m_cmd_valid", m_cmd_valid, 0);
    check("t6_rst_data_ready", s_data_ready, 0);
    check("t6_rst_cmd_ready", s_cmd_ready, 0);
    check("t6_rst_split_count", split_count, 0);
    s_data_valid = 1'b0;
    exp_cmd_q.delete();
    exp_beat_q.delete();
    e_seq = g_seq;
    repeat (2) @(posedge net_clk);
    @(negedge net_clk);
    net_areset = 1'b0;

    lerr_base = lerr_cnt;
    push_sub(64'h0, 32'd64, 4'h6);
    send_cmd(64'h0, 32'd64, 4'h6);
    send_beats(1, 0);
    wait_idle();
    check("t6_post_split_count", split_count, 0);
    check("t6_post_len_err", 32'(lerr_cnt - lerr_base), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
